// File: rtl/frac_clk_en_gen_pkg.sv
// Shared types for the fractional clock-enable generator.
// Lock FSM encoding, default widths and config validity rule.
package frac_clk_pkg;

  localparam int ACC_W_DEF = 16;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_LOCKED = 1'b1
  } lock_st_e;

  // A ratio is usable when both terms are nonzero and inc <= mod.
  function automatic logic cfg_is_valid(
    input logic [31:0] inc,
    input logic [31:0] mod
  );
    return (inc != 32'd0) && (mod != 32'd0) && (inc <= mod);
  endfunction

endpackage

// File: rtl/frac_clk_en_gen_if.sv
// Run-time ratio configuration port.
// The master drives requests; the slave answers ready/err.
interface frac_clk_en_gen_if #(
  parameter int ACC_W = 16
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic [ACC_W-1:0] cfg_mod;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_inc, cfg_mod,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_inc, cfg_mod,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/frac_clk_en_gen_ch.sv
// One fractional channel: phase accumulator plus
// registered enable strobe and toggle output.
module frac_clk_ch
  import frac_clk_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int DEF_INC = 1,
  parameter int DEF_MOD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [ACC_W-1:0] i_inc,
  input  logic [ACC_W-1:0] i_mod,
  input  logic             i_gate,
  output logic             o_ce,
  output logic             o_sq
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  logic [ACC_W-1:0] r_mod;
  logic             r_ce;
  logic             r_sq;

  logic [ACC_W:0]   w_sum;
  logic             w_hit;
  logic [ACC_W-1:0] w_nxt;

  // Extra sum bit keeps inc==mod==max from wrapping.
  assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_hit = (w_sum >= {1'b0, r_mod});
  assign w_nxt = w_hit ? ACC_W'(w_sum - {1'b0, r_mod})
                       : ACC_W'(w_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_inc <= ACC_W'(DEF_INC);
      r_mod <= ACC_W'(DEF_MOD);
      r_ce  <= 1'b0;
      r_sq  <= 1'b0;
    end else begin
      r_ce <= ~i_gate & w_hit;
      r_sq <= i_gate ? 1'b0 : (r_sq ^ w_hit);
      if (i_load) begin
        r_acc <= '0;
        r_inc <= i_inc;
        r_mod <= i_mod;
      end else begin
        r_acc <= w_nxt;
      end
    end
  end

  assign o_ce = r_ce;
  assign o_sq = r_sq;

endmodule

// File: rtl/frac_clk_en_gen.sv
// Multi-channel fractional clock-enable generator:
// lock FSM, config decode and NUM_CH accumulator channels.
module frac_clk_en_gen
  import frac_clk_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LOCK_CYCLES = 1024,
  parameter int DEF_INC     = 1,
  parameter int DEF_MOD     = 2,
  parameter int GATE_UNLOCK = 1
) (
  input  logic              clk,
  input  logic              rst,
  frac_clk_en_gen_if.slave  cfg,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] sq,
  output logic              locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES);

  lock_st_e         r_st;
  logic [CNT_W-1:0] r_cnt;
  logic             r_locked;
  logic             r_arm;
  logic             r_ready;
  logic             r_err;

  logic              w_xfer;
  logic              w_ch_ok;
  logic              w_ok;
  logic              w_acc;
  logic              w_rej;
  logic              w_gate;
  logic [NUM_CH-1:0] w_load;

  assign w_xfer  = cfg.cfg_valid & r_ready;
  assign w_ch_ok = ({29'd0, cfg.cfg_ch} < 32'(NUM_CH));
  assign w_ok    = w_ch_ok &
                   cfg_is_valid(32'(cfg.cfg_inc),
                                32'(cfg.cfg_mod));
  assign w_acc   = w_xfer & w_ok;
  assign w_rej   = w_xfer & ~w_ok;
  assign w_gate  = (GATE_UNLOCK != 0) & ~r_locked;

  // Ready comes up two cycles after reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arm   <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_arm   <= 1'b1;
      r_ready <= r_arm;
      r_err   <= w_rej;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st     <= ST_SETTLE;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (w_acc) begin
      r_st     <= ST_SETTLE;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else begin
      unique case (r_st)
        ST_SETTLE: begin
          if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
            r_st     <= ST_LOCKED;
            r_locked <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          r_locked <= 1'b1;
        end
        default: begin
          r_st     <= ST_SETTLE;
          r_cnt    <= '0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_load[g] = w_acc & (cfg.cfg_ch == 3'(g));

      frac_clk_ch #(
        .ACC_W   (ACC_W),
        .DEF_INC (DEF_INC),
        .DEF_MOD (DEF_MOD)
      ) u_ch (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load[g]),
        .i_inc  (cfg.cfg_inc),
        .i_mod  (cfg.cfg_mod),
        .i_gate (w_gate),
        .o_ce   (ce[g]),
        .o_sq   (sq[g])
      );
    end
  endgenerate

  assign cfg.cfg_ready = r_ready;
  assign cfg.cfg_err   = r_err;
  assign locked        = r_locked;

endmodule

// File: tb/tb_frac_clk_en_gen.sv
// Bench for frac_clk_en_gen: directed scenarios and random
// configs against an arithmetic rate/lock reference model.
module tb_frac_clk_en_gen;
  import frac_clk_pkg::*;

  localparam int NUM_CH = 2;
  localparam int ACC_W  = 16;
  localparam int L      = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] sq;
  logic              locked;

  int n_tests = 0;
  int n_fail  = 0;

  frac_clk_en_gen_if #(.ACC_W(ACC_W)) cfg_if ();

  frac_clk_en_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (L),
    .DEF_INC     (1),
    .DEF_MOD     (2),
    .GATE_UNLOCK (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cfg    (cfg_if),
    .ce     (ce),
    .sq     (sq),
    .locked (locked)
  );

  always #5 clk = ~clk;

  // Reference model: phase in units of 1/mod, lock by age.
  int m_acc [NUM_CH];
  int m_inc [NUM_CH];
  int m_mod [NUM_CH];
  bit m_ce  [NUM_CH];
  bit m_sq  [NUM_CH];
  int m_age;
  int m_rage;
  bit m_locked;
  bit m_err;

  function automatic logic [NUM_CH-1:0] mce();
    return {m_ce[1], m_ce[0]};
  endfunction

  function automatic logic [NUM_CH-1:0] msq();
    return {m_sq[1], m_sq[0]};
  endfunction

  task automatic step();
    bit rdy, ok, take;
    int ch, s;
    rdy  = (m_rage >= 2);
    ch   = int'(cfg_if.cfg_ch);
    ok   = (ch < NUM_CH) &&
           cfg_is_valid(32'(cfg_if.cfg_inc), 32'(cfg_if.cfg_mod));
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_acc[i] = 0; m_inc[i] = 1; m_mod[i] = 2;
        m_ce[i] = 0;  m_sq[i] = 0;
      end
      m_age = 0; m_rage = 0; m_locked = 0; m_err = 0;
    end else begin
      take  = cfg_if.cfg_valid && rdy && ok;
      m_err = cfg_if.cfg_valid && rdy && !ok;
      for (int i = 0; i < NUM_CH; i++) begin
        s = m_acc[i] + m_inc[i];
        if (m_locked) begin
          m_ce[i] = (s >= m_mod[i]);
          if (s >= m_mod[i]) m_sq[i] = !m_sq[i];
        end else begin
          m_ce[i] = 0;
          m_sq[i] = 0;
        end
        m_acc[i] = (s >= m_mod[i]) ? s - m_mod[i] : s;
        if (take && ch == i) begin
          m_acc[i] = 0;
          m_inc[i] = int'(cfg_if.cfg_inc);
          m_mod[i] = int'(cfg_if.cfg_mod);
        end
      end
      m_age    = take ? 0 : m_age + 1;
      m_locked = (m_age >= L);
      if (m_rage < 2) m_rage++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int inc, input int mod);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 3'(ch);
    cfg_if.cfg_inc   = ACC_W'(inc);
    cfg_if.cfg_mod   = ACC_W'(mod);
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_lock(input string tag);
    int n = 0;
    while (locked !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_lock_timeout locked=%b exp=1", tag, locked);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (ce !== 2'b00 || sq !== 2'b00 || locked !== 1'b0 ||
        cfg_if.cfg_ready !== 1'b0 || cfg_if.cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state ce=%b sq=%b lk=%b rdy=%b err=%b exp all 0",
               ce, sq, locked, cfg_if.cfg_ready, cfg_if.cfg_err);
    end
    rst = 1'b0;
    step();
    n = 1;
    n_tests++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_first got=%b exp=0", cfg_if.cfg_ready);
    end
    while (locked !== 1'b1 && n < 40) begin
      step();
      n++;
      n_tests++;
      if (ce !== mce()) begin
        n_fail++;
        $display("FAIL reset_ce got=%b exp=%b", ce, mce());
      end
    end
    n_tests++;
    if (n !== L) begin
      n_fail++;
      $display("FAIL reset_lock_time got=%0d exp=%0d", n, L);
    end
    n_tests++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_up got=%b exp=1", cfg_if.cfg_ready);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if (ce !== mce() || sq !== msq()) begin
        n_fail++;
        $display("FAIL default_pattern ce=%b sq=%b exp ce=%b sq=%b",
                 ce, sq, mce(), msq());
      end
    end
  endtask

  task automatic test_ratio13();
    int c0 = 0, c1 = 0;
    send(0, 1, 3);
    n_tests++;
    if (locked !== 1'b0 || cfg_if.cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL r13_unlock lk=%b err=%b exp 0 0",
               locked, cfg_if.cfg_err);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      n_tests++;
      if (ce !== mce() || locked !== m_locked) begin
        n_fail++;
        $display("FAIL r13_track ce=%b lk=%b exp ce=%b lk=%b",
                 ce, locked, mce(), m_locked);
      end
    end
    for (int i = 0; i < 30; i++) begin
      step();
      c0 += int'(ce[0]);
      c1 += int'(ce[1]);
    end
    n_tests++;
    if (c0 !== 10 || c1 !== 15) begin
      n_fail++;
      $display("FAIL r13_rate ce0=%0d ce1=%0d exp 10 15", c0, c1);
    end
  endtask

  task automatic test_rate_2_5();
    int pulses = 0, toggles = 0;
    logic prev;
    send(0, 2, 5);
    wait_lock("rate");
    prev = sq[0];
    for (int i = 0; i < 1000; i++) begin
      step();
      pulses += int'(ce[0]);
      if (sq[0] !== prev) toggles++;
      prev = sq[0];
    end
    n_tests++;
    if (pulses !== 400 || toggles !== 400) begin
      n_fail++;
      $display("FAIL rate_2_5 ce=%0d sq_tog=%0d exp 400 400",
               pulses, toggles);
    end
  endtask

  task automatic test_reject();
    int tch [3] = '{NUM_CH, 0, 0};
    int tinc[3] = '{1, 6, 1};
    int tmod[3] = '{2, 5, 0};
    for (int k = 0; k < 3; k++) begin
      send(tch[k], tinc[k], tmod[k]);
      n_tests++;
      if (cfg_if.cfg_err !== 1'b1 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL reject_%0d err=%b lk=%b exp 1 1",
                 k, cfg_if.cfg_err, locked);
      end
      step();
      n_tests++;
      if (cfg_if.cfg_err !== 1'b0) begin
        n_fail++;
        $display("FAIL reject_pulse_%0d err=%b exp 0", k, cfg_if.cfg_err);
      end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_tests++;
      if (ce !== mce() || sq !== msq() || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL reject_keep ce=%b sq=%b lk=%b exp %b %b 1",
                 ce, sq, locked, mce(), msq());
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    send(1, 1, 4);
    for (int i = 0; i < 10; i++) step();
    send(1, 3, 4);
    for (int i = 0; i < 5; i++) step();
    send(1, 1, 2);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_unlocked got=%b exp=0", locked);
    end
    while (locked !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    n_tests++;
    if (n !== L) begin
      n_fail++;
      $display("FAIL b2b_lock_time got=%0d exp=%0d", n, L);
    end
  endtask

  task automatic test_rst_with_cfg();
    int c0 = 0;
    wait_lock("rstcfg");
    rst = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 3'd0;
    cfg_if.cfg_inc   = 16'd3;
    cfg_if.cfg_mod   = 16'd7;
    step();
    n_tests++;
    if (ce !== 2'b00 || sq !== 2'b00 || locked !== 1'b0 ||
        cfg_if.cfg_err !== 1'b0 || cfg_if.cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cfg ce=%b sq=%b lk=%b err=%b rdy=%b exp all 0",
               ce, sq, locked, cfg_if.cfg_err, cfg_if.cfg_ready);
    end
    rst = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    wait_lock("rstcfg2");
    for (int i = 0; i < 20; i++) begin
      step();
      c0 += int'(ce[0]);
      n_tests++;
      if (ce !== mce() || sq !== msq()) begin
        n_fail++;
        $display("FAIL rst_defaults ce=%b sq=%b exp %b %b",
                 ce, sq, mce(), msq());
      end
    end
    n_tests++;
    if (c0 !== 10) begin
      n_fail++;
      $display("FAIL rst_default_rate got=%0d exp=10", c0);
    end
  endtask

  task automatic test_full_scale();
    logic prev;
    send(0, 16'hFFFF, 16'hFFFF);
    wait_lock("full");
    step();
    prev = sq[0];
    for (int i = 0; i < 50; i++) begin
      step();
      n_tests++;
      if (ce[0] !== 1'b1 || sq[0] === prev) begin
        n_fail++;
        $display("FAIL full_scale ce0=%b sq0=%b prev=%b exp ce0=1 toggle",
                 ce[0], sq[0], prev);
      end
      prev = sq[0];
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int k = 0; k < 40; k++) begin
      rst = ($urandom_range(0, 19) == 0);
      cfg_if.cfg_valid = 1'($urandom_range(0, 1));
      cfg_if.cfg_ch    = 3'($urandom_range(0, 2));
      cfg_if.cfg_inc   = ACC_W'($urandom_range(0, 12));
      cfg_if.cfg_mod   = ACC_W'($urandom_range(0, 12));
      step();
      rst = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cyc = $urandom_range(3, 30);
      for (int i = 0; i < cyc; i++) begin
        n_tests++;
        if (ce !== mce() || sq !== msq() || locked !== m_locked ||
            cfg_if.cfg_err !== m_err ||
            cfg_if.cfg_ready !== (m_rage >= 2)) begin
          n_fail++;
          $display("FAIL rand_%0d ce=%b sq=%b lk=%b err=%b exp %b %b %b %b",
                   k, ce, sq, locked, cfg_if.cfg_err,
                   mce(), msq(), m_locked, m_err);
        end
        step();
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = 3'd0;
    cfg_if.cfg_inc   = '0;
    cfg_if.cfg_mod   = '0;
    #2;
    test_reset();
    test_ratio13();
    test_rate_2_5();
    test_reject();
    test_back_to_back();
    test_rst_with_cfg();
    test_full_scale();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
